// File: rtl/ioctl_loader.sv
// ioctl_loader: turns the byte stream of a data_io download into word writes
// on a simple request/ready memory port.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   dlActive/dlIndex     download in progress / image index (low bits = slot)
//   dlWr/dlA/dlD         one-cycle byte strobe, byte offset, byte data
//   memW/memA/memD/memMask/memReady  write request presenting the FIFO head
//   busy/done            downloading or flushing / one-cycle completion pulse
//   loaded               per-slot "image written" flags (cleared only by reset)
//   ovf/drop             sticky: byte beyond slot size / word lost to full FIFO
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for dlActive
// LOAD  | accepting bytes into the pack register
// FLUSH | download ended, draining pack register and FIFO
// DONE  | one-cycle completion, loaded flag updated on entry
module ioctl_loader #(
    parameter int DW    = 8,
    parameter int AW    = 19,
    parameter int SLOTS = 4,
    parameter int FD    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dlActive,
    input  logic [7:0]           dlIndex,
    input  logic                 dlWr,
    input  logic [24:0]          dlA,
    input  logic [7:0]           dlD,
    output logic                 memW,
    output logic [AW-1:0]        memA,
    output logic [DW-1:0]        memD,
    output logic [DW/8-1:0]      memMask,
    input  logic                 memReady,
    output logic                 busy,
    output logic                 done,
    output logic [SLOTS-1:0]     loaded,
    output logic                 ovf,
    output logic                 drop
);

    localparam int NB    = DW / 8;
    localparam int LB    = $clog2(NB);
    localparam int SLOTW = $clog2(SLOTS);
    localparam int SW    = (SLOTW > 0) ? SLOTW : 1;
    localparam int OW    = AW - SLOTW;
    localparam int PW    = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW    = PW + 1;
    localparam logic [AW-1:0] OFF_MASK = AW'((64'd1 << OW) - 64'd1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             pk_valid_q, pk_valid_d;
    logic [AW-1:0]    pk_addr_q, pk_addr_d;
    logic [DW-1:0]    pk_data_q, pk_data_d;
    logic [NB-1:0]    pk_mask_q, pk_mask_d;
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, drop_q, drop_d, wrote_q, wrote_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [SLOTS-1:0] loaded_q, loaded_d;

    logic [AW-1:0]    fa_q [FD];
    logic [DW-1:0]    fd_q [FD];
    logic [NB-1:0]    fm_q [FD];

    logic [24:0]      lane_w, off_w;
    logic [AW-1:0]    byte_addr;
    logic             slot_ok, off_ovf, accept, acc_ok, acc_ovf;
    logic             load_entry, push, merge, pop, full, push_ok, push_drop;

    assign lane_w     = dlA & 25'(NB - 1);
    assign off_w      = dlA >> LB;
    assign off_ovf    = (off_w >> OW) != '0;
    assign slot_ok    = int'(dlIndex) < SLOTS;
    assign byte_addr  = (AW'(off_w) & OFF_MASK) | (AW'(dlIndex) << OW);

    assign load_entry = (state_q == S_IDLE) && dlActive;
    assign accept     = (state_q == S_LOAD) && dlActive && dlWr && slot_ok;
    assign acc_ok     = accept && !off_ovf;
    assign acc_ovf    = accept && off_ovf;

    // A word whose top lane has been written is held one cycle in the pack
    // register and pushed on the next cycle; this keeps a single FIFO write
    // port even when a new-address byte and a completed word coincide.
    assign push       = pk_valid_q && (pk_mask_q[NB-1]
                                       || (acc_ok && byte_addr != pk_addr_q)
                                       || state_q == S_FLUSH);
    assign merge      = pk_valid_q && !push;

    assign memW       = cnt_q != '0;
    assign pop        = memW && memReady;
    assign full       = cnt_q == CW'(FD);
    assign push_ok    = push && (!full || pop);
    assign push_drop  = push && full && !pop;

    // Outputs are zeroed while idle so reset presents a clean bus.
    assign memA       = memW ? fa_q[rp_q] : '0;
    assign memD       = memW ? fd_q[rp_q] : '0;
    assign memMask    = memW ? fm_q[rp_q] : '0;
    assign busy       = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign done       = state_q == S_DONE;
    assign loaded     = loaded_q;
    assign ovf        = ovf_q;
    assign drop       = drop_q;

    always_comb begin
        pk_valid_d = pk_valid_q;
        pk_addr_d  = pk_addr_q;
        pk_data_d  = pk_data_q;
        pk_mask_d  = pk_mask_q;
        if (push) begin
            pk_valid_d = 1'b0;
            pk_data_d  = '0;
            pk_mask_d  = '0;
        end
        if (acc_ok) begin
            if (!merge) begin
                pk_data_d = '0;
                pk_mask_d = '0;
            end
            pk_valid_d = 1'b1;
            pk_addr_d  = byte_addr;
            for (int i = 0; i < NB; i++) begin
                if (lane_w == 25'(i)) begin
                    pk_data_d[i*8 +: 8] = dlD;
                    pk_mask_d[i]        = 1'b1;
                end
            end
        end
        if (load_entry) begin
            pk_valid_d = 1'b0;
            pk_addr_d  = '0;
            pk_data_d  = '0;
            pk_mask_d  = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        wrote_d  = wrote_q;
        slot_d   = slot_q;
        loaded_d = loaded_q;

        if (push_ok) wp_d = wp_q + PW'(1);
        if (pop)     rp_d = rp_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (acc_ovf)   ovf_d   = 1'b1;
        if (push_drop) drop_d  = 1'b1;
        if (pop)       wrote_d = 1'b1;
        if (acc_ok)    slot_d  = dlIndex[SW-1:0];

        case (state_q)
            S_IDLE: begin
                if (dlActive) begin
                    state_d = S_LOAD;
                    wp_d    = '0;
                    rp_d    = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    drop_d  = 1'b0;
                    wrote_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (!dlActive) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (!pk_valid_q && cnt_q == '0) begin
                    state_d = S_DONE;
                    if (wrote_q) loaded_d[slot_q] = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pk_valid_q <= 1'b0;
            pk_addr_q  <= '0;
            pk_data_q  <= '0;
            pk_mask_q  <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
            wrote_q    <= 1'b0;
            slot_q     <= '0;
            loaded_q   <= '0;
        end else begin
            state_q    <= state_d;
            pk_valid_q <= pk_valid_d;
            pk_addr_q  <= pk_addr_d;
            pk_data_q  <= pk_data_d;
            pk_mask_q  <= pk_mask_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            wrote_q    <= wrote_d;
            slot_q     <= slot_d;
            loaded_q   <= loaded_d;
        end
    end

    // Storage needs no reset: entries are only visible while cnt_q covers them.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fa_q[wp_q] <= pk_addr_q;
            fd_q[wp_q] <= pk_data_q;
            fm_q[wp_q] <= pk_mask_q;
        end
    end

endmodule

// File: doc/ioctl_loader.md
IOCTL_LOADER -- requirements
Module: ioctl_loader

Interface
REQ-001 SHALL have parameter DW, default 8, memory data width in bits (8, 16 or 32).
REQ-002 SHALL have parameter AW, default 19, memory word-address width.
REQ-003 SHALL have parameter SLOTS, default 4, number of image slots (power of two, >=1); SLOTW = clog2(SLOTS), LB = clog2(DW/8).
REQ-004 SHALL have parameter FD, default 2, write-FIFO depth in words (power of two, >=2).
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 dlActive  in  1  download in progress, from the data_io block.
REQ-009 dlIndex  in  8  image index; bits SLOTW-1:0 select the slot.
REQ-010 dlWr  in  1  one-cycle byte strobe.
REQ-011 dlA  in  25  byte offset within the image.
REQ-012 dlD  in  8  byte data.
REQ-013 memW  out  1  write request; memA  out  AW; memD  out  DW; memMask  out  DW/8  byte enables.
REQ-014 memReady  in  1  memory accepts the request this cycle.
REQ-015 busy  out  1; done  out  1; loaded  out  SLOTS; ovf  out  1; drop  out  1.

Function
REQ-016 SHALL use states IDLE, LOAD, FLUSH, DONE; reset and power-up state SHALL be IDLE.
REQ-017 IDLE->LOAD when dlActive=1; LOAD->FLUSH when dlActive=0; FLUSH->DONE when the pack register and FIFO are empty and memW=0; DONE->IDLE after one cycle.
REQ-018 busy SHALL be 1 in LOAD and FLUSH; done SHALL be 1 only in DONE (one-cycle pulse).
REQ-019 dlWr SHALL be honoured only in LOAD with dlActive=1; other bytes are ignored.
REQ-020 Byte lane SHALL be dlA[LB-1:0], little-endian (lane 0 = bits 7:0); word offset = dlA[24:LB].
REQ-021 Slot index >= SLOTS SHALL discard all bytes of that download; no flag changes.
REQ-022 Word offset >= 2^(AW-SLOTW) SHALL discard the byte and set ovf (sticky until next LOAD entry or reset).
REQ-023 memA SHALL be {dlIndex[SLOTW-1:0], offset[AW-SLOTW-1:0]}.
REQ-024 The pack register SHALL accumulate bytes and their lane mask; it SHALL push {addr,data,mask} to the FIFO when lane DW/8-1 is written, when a byte arrives for a different word address (pending partial word pushed first, in the same cycle as the new byte is accepted), or on entry to FLUSH if non-empty.
REQ-025 DW=8 SHALL push every accepted byte with mask 1.
REQ-026 Push when the FIFO is full and no pop occurs SHALL discard the word and set drop (sticky until next LOAD entry or reset); a simultaneous pop and push SHALL both succeed.
REQ-027 memW/memA/memD/memMask SHALL present the FIFO head; a transfer completes when memW=1 and memReady=1, popping the head; outputs SHALL be stable while memW=1 and memReady=0.
REQ-028 Latency: a completed word SHALL reach memW=1 no later than 2 cycles after the byte completing it.
REQ-029 loaded[slot] SHALL be set on entry to DONE for the slot of that download if at least one word was written; it is never cleared except by reset.
REQ-030 Entry to LOAD SHALL clear ovf, drop, the pack register and the FIFO.

Reset
REQ-031 reset SHALL force IDLE, memW=0, memA=0, memD=0, memMask=0, busy=0, done=0, loaded=0, ovf=0, drop=0, FIFO and pack register empty, in the cycle after it is sampled high.
REQ-032 Reset during LOAD SHALL abandon pending words; if dlActive is still 1 after reset releases, the block SHALL enter LOAD as a fresh download.

Verification
REQ-033 DW=16, AW=19, SLOTS=4, memReady=1: index 1, bytes 11,22,33,44 at dlA 0..3 -> writes (A=0x20000, D=0x2211, M=11), (A=0x20001, D=0x4433, M=11); done pulses once; loaded=0010.
REQ-034 Same, 3 bytes 11,22,33 -> last write A=0x20001, D[7:0]=0x33, M=01, issued in FLUSH.
REQ-035 memReady=0 for 20 cycles while 8 bytes arrive (FD=2) -> drop=1, memA/memD stable while stalled, 2 words written after memReady=1, busy held until FIFO empty.
REQ-036 Index 0, byte at dlA=0x40000 -> no write, ovf=1, loaded[0]=0; index 6 download -> no writes, no flags set.
REQ-037 reset asserted mid-LOAD with memW=1 -> next cycle memW=0, loaded=0, busy=0; with dlActive still 1, busy=1 again one cycle after reset releases.
